ai_emotion_analyzer_core: RTL and testbench



---
 rtl/emotion_pkg.sv | 64 ++++++
 rtl/note_history_buffer.sv | 78 +++++++
 rtl/ai_emotion_analyzer_core.sv | 116 +++++++++++
 tb/tb_ai_emotion_analyzer_core.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/emotion_pkg.sv
// Shared constants, FSM state type and the decision rule table for the melody
// emotion classifier.
package emotion_pkg;

   localparam logic [1:0] NEUTRAL = 2'b00;
   localparam logic [1:0] HAPPY   = 2'b01;
   localparam logic [1:0] SAD     = 2'b10;
   localparam logic [1:0] TENSE   = 2'b11;

   localparam int SEMI_THRESH      = 8;
   localparam int LEAP_THRESH      = 6;
   localparam int LEAP_MIN         = 7;
   localparam int CONF_SCALE       = 17;
   localparam int NEUTRAL_TIE_CONF = 128;
   localparam int BUF_DEPTH        = 16;

   localparam int NOTE_W = 6;
   localparam int IDX_W  = 4;
   localparam int CNT_W  = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DECIDE,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [1:0] code;
      logic [7:0] conf;
   } decision_t;

   // Counts never exceed 15, so the 8-bit product cannot overflow.
   function automatic logic [7:0] scale_conf(input logic [CNT_W-1:0] n);
      return 8'(n) * 8'(CONF_SCALE);
   endfunction

   function automatic decision_t decide_emotion(
      input logic [CNT_W-1:0] up,
      input logic [CNT_W-1:0] down,
      input logic [CNT_W-1:0] semi,
      input logic [CNT_W-1:0] leap
   );
      decision_t r;
      if (semi >= CNT_W'(SEMI_THRESH)) begin
         r.code = NEUTRAL;
         r.conf = scale_conf(semi);
      end else if (leap >= CNT_W'(LEAP_THRESH)) begin
         r.code = TENSE;
         r.conf = scale_conf(leap);
      end else if (up > down) begin
         r.code = HAPPY;
         r.conf = scale_conf(up - down);
      end else if (down > up) begin
         r.code = SAD;
         r.conf = scale_conf(down - up);
      end else begin
         r.code = NEUTRAL;
         r.conf = 8'(NEUTRAL_TIE_CONF);
      end
      return r;
   endfunction

endpackage

// File: rtl/note_history_buffer.sv
// Sliding 16-note history: appends until full, then shifts out the oldest note.
// The read port returns an adjacent pair (idx, idx+1) one clock after the index.
module note_history_buffer
   import emotion_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load_en,
   input  logic [NOTE_W-1:0] note_in,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [NOTE_W-1:0] rd_note_a,
   output logic [NOTE_W-1:0] rd_note_b,
   output logic              buffer_full
);

   logic [NOTE_W-1:0] entry_q [BUF_DEPTH];
   logic [CNT_W-1:0]  count_reg;
   logic              full_reg;
   logic [NOTE_W-1:0] rd_a_reg;
   logic [NOTE_W-1:0] rd_b_reg;
   logic [IDX_W-1:0]  rd_idx_b;

   // The analyzer never asks for index 15, so the wrap of idx+1 is harmless.
   assign rd_idx_b = rd_idx + IDX_W'(1);

   genvar gi;
   generate
      for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
         logic [NOTE_W-1:0] entry_reg;
         logic [NOTE_W-1:0] shift_src;

         if (gi == BUF_DEPTH - 1) begin : g_top
            assign shift_src = note_in;
         end else begin : g_mid
            assign shift_src = entry_q[gi+1];
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               entry_reg <= '0;
            end else if (load_en) begin
               if (full_reg) begin
                  entry_reg <= shift_src;
               end else if (count_reg == CNT_W'(gi)) begin
                  entry_reg <= note_in;
               end
            end
         end

         assign entry_q[gi] = entry_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
         full_reg  <= 1'b0;
      end else if (load_en && !full_reg) begin
         count_reg <= count_reg + CNT_W'(1);
         full_reg  <= (count_reg == CNT_W'(BUF_DEPTH - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_a_reg <= '0;
         rd_b_reg <= '0;
      end else begin
         rd_a_reg <= entry_q[rd_idx];
         rd_b_reg <= entry_q[rd_idx_b];
      end
   end

   assign rd_note_a   = rd_a_reg;
   assign rd_note_b   = rd_b_reg;
   assign buffer_full = full_reg;

endmodule

// File: rtl/ai_emotion_analyzer_core.sv
// Melody emotion classifier: scans the 15 intervals of the note history and
// maps interval statistics to an emotion code with an 8-bit confidence.
module ai_emotion_analyzer_core
   import emotion_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       enable_ai,
   input  logic [5:0] note_played,
   input  logic       load_new_note,
   output logic [1:0] emotion_code,
   output logic [7:0] emotion_confidence,
   output logic       emotion_ready,
   output logic       buffer_full
);

   state_t            state_reg;
   logic [IDX_W-1:0]  scan_idx_reg;
   logic              pair_valid_reg;
   logic [CNT_W-1:0]  up_reg;
   logic [CNT_W-1:0]  down_reg;
   logic [CNT_W-1:0]  semi_reg;
   logic [CNT_W-1:0]  leap_reg;
   logic [1:0]        code_reg;
   logic [7:0]        conf_reg;
   logic              ready_reg;

   logic              load_en;
   logic [NOTE_W-1:0] rd_note_a;
   logic [NOTE_W-1:0] rd_note_b;
   logic signed [6:0] interval;
   logic [6:0]        interval_mag;
   decision_t         decision;

   assign load_en = load_new_note && (state_reg == ST_IDLE);

   note_history_buffer u_history (
      .clk         (clk),
      .reset       (reset),
      .load_en     (load_en),
      .note_in     (note_played),
      .rd_idx      (scan_idx_reg),
      .rd_note_a   (rd_note_a),
      .rd_note_b   (rd_note_b),
      .buffer_full (buffer_full)
   );

   assign interval     = $signed({1'b0, rd_note_b}) - $signed({1'b0, rd_note_a});
   assign interval_mag = interval[6] ? 7'(-interval) : 7'(interval);
   assign decision     = decide_emotion(up_reg, down_reg, semi_reg, leap_reg);

   // The read port lags the scan index by one clock, so counters accumulate
   // one cycle behind SCAN and DECIDE waits for the last interval to drain.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         scan_idx_reg   <= '0;
         pair_valid_reg <= 1'b0;
         up_reg         <= '0;
         down_reg       <= '0;
         semi_reg       <= '0;
         leap_reg       <= '0;
         code_reg       <= NEUTRAL;
         conf_reg       <= '0;
         ready_reg      <= 1'b0;
      end else begin
         pair_valid_reg <= (state_reg == ST_SCAN);

         if (pair_valid_reg) begin
            if (interval > 7'sd0)             up_reg   <= up_reg + CNT_W'(1);
            if (interval < 7'sd0)             down_reg <= down_reg + CNT_W'(1);
            if (interval_mag == 7'd1)         semi_reg <= semi_reg + CNT_W'(1);
            if (interval_mag >= 7'(LEAP_MIN)) leap_reg <= leap_reg + CNT_W'(1);
         end

         case (state_reg)
            ST_IDLE: begin
               if (enable_ai && buffer_full) begin
                  up_reg       <= '0;
                  down_reg     <= '0;
                  semi_reg     <= '0;
                  leap_reg     <= '0;
                  scan_idx_reg <= '0;
                  state_reg    <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               scan_idx_reg <= scan_idx_reg + IDX_W'(1);
               if (scan_idx_reg == IDX_W'(BUF_DEPTH - 2)) begin
                  state_reg <= ST_DECIDE;
               end
            end
            ST_DECIDE: begin
               if (!pair_valid_reg) begin
                  code_reg  <= decision.code;
                  conf_reg  <= decision.conf;
                  ready_reg <= 1'b1;
                  state_reg <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!enable_ai) begin
                  ready_reg <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign emotion_code       = code_reg;
   assign emotion_confidence = conf_reg;
   assign emotion_ready      = ready_reg;

endmodule

// File: tb/tb_ai_emotion_analyzer_core.sv
// Directed and randomized bench for the emotion classifier, checked against a
// queue-based interval-statistics model.
module tb_ai_emotion_analyzer_core;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable_ai;
   logic [5:0] note_played;
   logic       load_new_note;
   logic [1:0] emotion_code;
   logic [7:0] emotion_confidence;
   logic       emotion_ready;
   logic       buffer_full;

   int checks = 0;
   int errors = 0;
   int hist[$];

   int pat_happy[8] = '{30, 32, 34, 35, 37, 39, 41, 42};
   int pat_sad[8]   = '{59, 57, 56, 54, 52, 51, 49, 47};
   int pat_mix[16]  = '{48, 52, 55, 45, 48, 52, 41, 45, 48, 43, 47, 50, 48, 52, 55, 45};

   always #5 clk = ~clk;

   ai_emotion_analyzer_core dut (
      .clk                (clk),
      .reset              (reset),
      .enable_ai          (enable_ai),
      .note_played        (note_played),
      .load_new_note      (load_new_note),
      .emotion_code       (emotion_code),
      .emotion_confidence (emotion_confidence),
      .emotion_ready      (emotion_ready),
      .buffer_full        (buffer_full)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_push(input int n);
      if (hist.size() == 16) void'(hist.pop_front());
      hist.push_back(n);
   endfunction

   // Classification straight from the rule list: count interval kinds, then
   // apply the priority order.
   function automatic void model_expect(output int code, output int conf);
      int up = 0, dn = 0, semi = 0, leap = 0, d;
      for (int i = 0; i < 15; i++) begin
         d = hist[i+1] - hist[i];
         if (d > 0) up++;
         if (d < 0) dn++;
         if (d == 1 || d == -1) semi++;
         if (d >= 7 || d <= -7) leap++;
      end
      if (semi >= 8)      begin code = 0; conf = semi * 17; end
      else if (leap >= 6) begin code = 3; conf = leap * 17; end
      else if (up > dn)   begin code = 1; conf = (up - dn) * 17; end
      else if (dn > up)   begin code = 2; conf = (dn - up) * 17; end
      else                begin code = 0; conf = 128; end
   endfunction

   // All tasks start and end just after a falling edge.
   task automatic do_reset(input string tag);
      reset = 1'b1;
      @(negedge clk);
      chk({tag, ".rst_code"}, emotion_code, 0);
      chk({tag, ".rst_conf"}, emotion_confidence, 0);
      chk({tag, ".rst_ready"}, emotion_ready, 0);
      chk({tag, ".rst_full"}, buffer_full, 0);
      reset = 1'b0;
      hist.delete();
   endtask

   task automatic load_note(input int n);
      load_new_note = 1'b1;
      note_played   = 6'(n);
      @(negedge clk);
      load_new_note = 1'b0;
      model_push(n);
   endtask

   // Entered just after the edge before the one that starts the scan.
   task automatic wait_result(input string tag, input bit probe_load);
      int ec, ef;
      model_expect(ec, ef);
      repeat (17) @(negedge clk);
      chk({tag, ".not_yet_ready"}, emotion_ready, 0);
      @(negedge clk);
      chk({tag, ".ready"}, emotion_ready, 1);
      chk({tag, ".code"}, emotion_code, ec);
      chk({tag, ".conf"}, emotion_confidence, ef);
      if (probe_load) begin
         load_new_note = 1'b1;
         note_played   = 6'($urandom_range(0, 63));
         @(negedge clk);
         load_new_note = 1'b0;
         chk({tag, ".hold_ready"}, emotion_ready, 1);
      end
      enable_ai = 1'b0;
      @(negedge clk);
      chk({tag, ".ready_fall"}, emotion_ready, 0);
      chk({tag, ".code_held"}, emotion_code, ec);
      $display("txn %s: notes=%0d code=%0d conf=%0d expected code=%0d conf=%0d",
               tag, hist.size(), emotion_code, emotion_confidence, ec, ef);
   endtask

   task automatic run_analysis(input string tag, input bit probe_load);
      chk({tag, ".full"}, buffer_full, 1);
      enable_ai = 1'b1;
      wait_result(tag, probe_load);
   endtask

   initial begin
      int n, cur, mode;
      reset         = 1'b1;
      enable_ai     = 1'b0;
      load_new_note = 1'b0;
      note_played   = '0;
      @(negedge clk);

      do_reset("init");
      for (int r = 0; r < 2; r++) foreach (pat_happy[i]) load_note(pat_happy[i]);
      run_analysis("happy", 1'b0);
      chk("happy.const_code", emotion_code, 1);
      chk("happy.const_conf", emotion_confidence, 221);

      do_reset("sad");
      for (int r = 0; r < 2; r++) foreach (pat_sad[i]) load_note(pat_sad[i]);
      run_analysis("sad", 1'b0);
      chk("sad.const_code", emotion_code, 2);
      chk("sad.const_conf", emotion_confidence, 221);

      do_reset("chrom");
      for (int i = 59; i >= 44; i--) load_note(i);
      run_analysis("chrom", 1'b0);
      chk("chrom.const_conf", emotion_confidence, 255);

      do_reset("mix");
      foreach (pat_mix[i]) load_note(pat_mix[i]);
      run_analysis("mix", 1'b0);
      chk("mix.const_code", emotion_code, 1);
      chk("mix.const_conf", emotion_confidence, 85);

      // Enable before the buffer fills: the analyzer must wait for the 16th note.
      do_reset("late");
      for (int i = 0; i < 15; i++) load_note(10 + 2 * i);
      enable_ai = 1'b1;
      repeat (20) @(negedge clk);
      chk("late.wait_ready", emotion_ready, 0);
      chk("late.wait_full", buffer_full, 0);
      load_new_note = 1'b1;
      note_played   = 6'd9;
      @(negedge clk);
      load_new_note = 1'b0;
      model_push(9);
      chk("late.full_rise", buffer_full, 1);
      wait_result("late", 1'b0);

      // Large alternating leaps, then a reset in the middle of a rescan.
      do_reset("tense");
      for (int i = 0; i < 16; i++) load_note((i % 2 == 0) ? 20 : 40);
      run_analysis("tense", 1'b0);
      chk("tense.const_code", emotion_code, 3);
      chk("tense.const_conf", emotion_confidence, 255);
      enable_ai = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort.code", emotion_code, 0);
      chk("abort.conf", emotion_confidence, 0);
      chk("abort.ready", emotion_ready, 0);
      chk("abort.full", buffer_full, 0);
      reset = 1'b0;
      hist.delete();
      repeat (20) @(negedge clk);
      chk("abort.no_restart", emotion_ready, 0);
      enable_ai = 1'b0;
      @(negedge clk);

      // Randomized melodies; a load attempted in DONE must be ignored, so a
      // second analysis of the same buffer must give the same answer.
      for (int r = 0; r < 8; r++) begin
         do_reset($sformatf("rnd%0d", r));
         n    = 16 + $urandom_range(0, 8);
         mode = $urandom_range(0, 2);
         cur  = $urandom_range(10, 53);
         for (int i = 0; i < n; i++) begin
            if (mode == 0) cur = $urandom_range(0, 63);
            else if (mode == 1) cur = cur + $urandom_range(0, 4) - 2;
            else cur = cur + $urandom_range(0, 20) - 10;
            if (cur < 0) cur = 0;
            if (cur > 63) cur = 63;
            load_note(cur);
         end
         run_analysis($sformatf("rnd%0d.a", r), 1'b1);
         run_analysis($sformatf("rnd%0d.b", r), 1'b0);
         load_note($urandom_range(0, 63));
         run_analysis($sformatf("rnd%0d.c", r), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
